// File: rtl/nordstrom_checkout_ctrl.sv
// Checkout-lane sequencer: captures scan requests, drives the item detector and
// keeps per-transaction item/discount totals with a latched theft alarm.
module nordstrom_checkout_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_ITEMS = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan,
  input  logic [3:0]       item_code,
  input  logic             clear,
  output logic [3:0]       det_code,
  input  logic             det_discount,
  input  logic             det_stolen,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] disc_count,
  output logic             alarm,
  output logic             full,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StEval,
    StAlarm,
    StFull
  } state_e;

  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(MAX_ITEMS);

  state_e           state_q, state_d;
  logic             scan_q;
  logic [3:0]       det_code_q, det_code_d;
  logic [CNT_W-1:0] item_q, item_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic             done_q, done_d;
  logic             req;

  assign req = scan & ~scan_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      scan_q     <= 1'b1;  // scan held high through reset is not a request
      det_code_q <= '0;
      item_q     <= '0;
      disc_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_q     <= scan;
      det_code_q <= det_code_d;
      item_q     <= item_d;
      disc_q     <= disc_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    det_code_d = det_code_q;
    item_d     = item_q;
    disc_d     = disc_q;
    done_d     = 1'b0;
    // clear outranks any request or evaluation result in the same cycle
    if (clear) begin
      state_d = StIdle;
      item_d  = '0;
      disc_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            det_code_d = item_code;
            state_d    = StCapture;
          end
        end
        StCapture: state_d = StEval;
        StEval: begin
          if (det_stolen) begin
            state_d = StAlarm;
          end else begin
            item_d = item_q + CNT_W'(1);
            if (det_discount) disc_d = disc_q + CNT_W'(1);
            done_d  = 1'b1;
            state_d = (item_d == MaxCount) ? StFull : StIdle;
          end
        end
        StAlarm, StFull: state_d = state_q;
        default: state_d = StIdle;
      endcase
    end
  end

  assign det_code   = det_code_q;
  assign item_count = item_q;
  assign disc_count = disc_q;
  assign done       = done_q;
  assign alarm      = (state_q == StAlarm);
  assign full       = (state_q == StFull);
  assign busy       = (state_q == StCapture) || (state_q == StEval);

endmodule
